// File: rtl/hilo_muldiv.sv
// HI/LO register pair with single-cycle multiply and a 32-step restoring divider.
// Divides occupy the unit for WIDTH+1 cycles and can be flushed by md_cancel.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             md_cancel,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

    state_t             r_state, w_nxt;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_done, r_dbz;
    logic [WIDTH-1:0]   r_q, r_rem, r_dvs, r_xorig;
    logic               r_sq, r_sr, r_zero;
    logic [CW-1:0]      r_cnt;
    logic               w_accept;

    // Sign-extend only for MULT so one 2W-bit multiplier serves both flavours.
    logic               w_sext;
    logic [2*WIDTH-1:0] w_mx, w_my, w_prod;
    assign w_sext = (md_op == OP_MULT);
    assign w_mx   = {{WIDTH{w_sext & X[WIDTH-1]}}, X};
    assign w_my   = {{WIDTH{w_sext & Y[WIDTH-1]}}, Y};
    assign w_prod = w_mx * w_my;

    logic [WIDTH-1:0]   w_xabs, w_yabs;
    assign w_xabs = X[WIDTH-1] ? -X : X;
    assign w_yabs = Y[WIDTH-1] ? -Y : Y;

    // Partial remainder needs one extra bit since an unsigned divisor may use all WIDTH bits.
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_sub;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_rem_nxt;
    assign w_rem_sh  = {r_rem, r_q[WIDTH-1]};
    assign w_sub     = {1'b0, w_rem_sh} - {2'b00, r_dvs};
    assign w_borrow  = w_sub[WIDTH+1];
    assign w_rem_nxt = w_borrow ? w_rem_sh[WIDTH-1:0] : w_sub[WIDTH-1:0];

    logic [WIDTH-1:0]   w_q_fix, w_r_fix;
    assign w_q_fix = r_sq ? -r_q : r_q;
    assign w_r_fix = r_sr ? -r_rem : r_rem;

    always_comb begin
        w_nxt    = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = md_start && !md_cancel && (md_op != 3'd0) && (md_op != 3'd7);
                if (w_accept && (md_op == OP_DIV || md_op == OP_DIVU))
                    w_nxt = S_DIV;
            end
            S_DIV: begin
                if (md_cancel)
                    w_nxt = S_IDLE;
                else if (r_cnt == CW'(WIDTH - 1))
                    w_nxt = S_FIX;
            end
            S_FIX:   w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_q     <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_xorig <= '0;
            r_sq    <= 1'b0;
            r_sr    <= 1'b0;
            r_zero  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            r_done  <= (r_state == S_FIX) && !md_cancel;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_dbz <= 1'b0;
                    case (md_op)
                        OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_prod;
                        OP_MTHI: r_hi <= X;
                        OP_MTLO: r_lo <= X;
                        default: begin
                            r_q     <= (md_op == OP_DIV) ? w_xabs : X;
                            r_dvs   <= (md_op == OP_DIV) ? w_yabs : Y;
                            r_sq    <= (md_op == OP_DIV) && (X[WIDTH-1] ^ Y[WIDTH-1]);
                            r_sr    <= (md_op == OP_DIV) && X[WIDTH-1];
                            r_zero  <= (Y == '0);
                            r_xorig <= X;
                            r_rem   <= '0;
                            r_cnt   <= '0;
                        end
                    endcase
                end
                S_DIV: if (!md_cancel) begin
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[WIDTH-2:0], ~w_borrow};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: if (!md_cancel) begin
                    r_hi  <= r_zero ? r_xorig : w_r_fix;
                    r_lo  <= r_zero ? '1 : w_q_fix;
                    r_dbz <= r_zero;
                end
                default: ;
            endcase
        end
    end

    assign md_busy     = (r_state != S_IDLE);
    assign md_done     = r_done;
    assign hi_out      = r_hi;
    assign lo_out      = r_lo;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed vector table plus hand-written cancel/reset sequences for hilo_muldiv.
module tb_hilo_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic        md_start, md_cancel;
    logic [2:0]  md_op;
    logic [31:0] X, Y;
    logic        md_busy, md_done, div_by_zero;
    logic [31:0] hi_out, lo_out;

    int errors = 0;
    int checks = 0;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op), .X(X), .Y(Y),
        .md_cancel(md_cancel), .md_busy(md_busy), .md_done(md_done),
        .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x, y, hi, lo;
        logic        dbz;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pulse md_start for one cycle; returns at the negedge just after the accepting edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        md_start = 1'b1; md_op = op; X = x; Y = y;
        @(negedge clk);
        md_start = 1'b0; md_op = 3'd0;
    endtask

    task automatic run_vec(input int idx);
        int nbusy, ndone, ebusy, edone;
        nbusy = 0; ndone = 0;
        start_op(vt[idx].op, vt[idx].x, vt[idx].y);
        for (int c = 0; c < 36; c++) begin
            if (md_busy) nbusy++;
            if (md_done) ndone++;
            @(negedge clk);
        end
        ebusy = (vt[idx].op == 3'd3 || vt[idx].op == 3'd4) ? 33 : 0;
        edone = (ebusy != 0) ? 1 : 0;
        chk($sformatf("v%0d hi", idx), hi_out, vt[idx].hi);
        chk($sformatf("v%0d lo", idx), lo_out, vt[idx].lo);
        chk($sformatf("v%0d dbz", idx), {31'd0, div_by_zero}, {31'd0, vt[idx].dbz});
        chk($sformatf("v%0d busy_cycles", idx), nbusy, ebusy);
        chk($sformatf("v%0d done_pulses", idx), ndone, edone);
    endtask

    initial begin
        int nd;
        vt[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vt[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vt[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[3]  = '{3'd4, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
        vt[4]  = '{3'd6, 32'd5,        32'd0,        32'd100,      32'd5,        1'b0};
        vt[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vt[6]  = '{3'd4, 32'd50,       32'd7,        32'd1,        32'd7,        1'b0};
        vt[7]  = '{3'd5, 32'h11,       32'd0,        32'h11,       32'd7,        1'b0};
        vt[8]  = '{3'd6, 32'h22,       32'd0,        32'h11,       32'h22,       1'b0};
        vt[9]  = '{3'd3, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0};
        vt[10] = '{3'd4, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0};
        vt[11] = '{3'd0, 32'h1,        32'h1,        32'hF,        32'h0FFFFFFF, 1'b0};
        vt[12] = '{3'd4, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        32'd1,        1'b0};
        vt[13] = '{3'd3, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vt[14] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

        rst = 1'b1; md_start = 1'b0; md_cancel = 1'b0; md_op = 3'd0; X = '0; Y = '0;
        repeat (2) @(negedge clk);
        chk("rst hi", hi_out, 32'd0);
        chk("rst lo", lo_out, 32'd0);
        chk("rst busy", {31'd0, md_busy}, 32'd0);
        chk("rst done", {31'd0, md_done}, 32'd0);
        chk("rst dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(i);

        // Cancel at busy cycle 10 keeps HI/LO and suppresses md_done.
        start_op(3'd5, 32'h11, 32'd0);
        start_op(3'd6, 32'h22, 32'd0);
        start_op(3'd4, 32'd50, 32'd7);
        repeat (9) @(negedge clk);
        chk("cancel pre busy", {31'd0, md_busy}, 32'd1);
        md_cancel = 1'b1;
        @(negedge clk);
        md_cancel = 1'b0;
        chk("cancel busy drop", {31'd0, md_busy}, 32'd0);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (md_done) nd++;
            @(negedge clk);
        end
        chk("cancel no done", nd, 0);
        chk("cancel hi", hi_out, 32'h11);
        chk("cancel lo", lo_out, 32'h22);

        // MTHI during a divide is dropped; the divide still completes.
        start_op(3'd4, 32'd50, 32'd7);
        md_start = 1'b1; md_op = 3'd5; X = 32'hAA;
        @(negedge clk);
        md_start = 1'b0; md_op = 3'd0;
        chk("busy ignore hi", hi_out, 32'h11);
        repeat (36) @(negedge clk);
        chk("busy div hi", hi_out, 32'd1);
        chk("busy div lo", lo_out, 32'd7);

        // Cancel in IDLE blocks a same-cycle start.
        md_start = 1'b1; md_op = 3'd6; X = 32'h99; md_cancel = 1'b1;
        @(negedge clk);
        md_start = 1'b0; md_op = 3'd0; md_cancel = 1'b0;
        @(negedge clk);
        chk("idle cancel lo", lo_out, 32'd7);

        // Cancel during the FIX cycle suppresses the write.
        start_op(3'd5, 32'h55, 32'd0);
        start_op(3'd6, 32'h33, 32'd0);
        start_op(3'd4, 32'd50, 32'd7);
        repeat (32) @(negedge clk);
        chk("fix still busy", {31'd0, md_busy}, 32'd1);
        md_cancel = 1'b1;
        @(negedge clk);
        md_cancel = 1'b0;
        chk("fix cancel busy", {31'd0, md_busy}, 32'd0);
        chk("fix cancel done", {31'd0, md_done}, 32'd0);
        chk("fix cancel hi", hi_out, 32'h55);
        chk("fix cancel lo", lo_out, 32'h33);

        // Async reset mid-divide clears everything without a clock edge.
        run_vec(3);
        start_op(3'd4, 32'd50, 32'd7);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst hi", hi_out, 32'd0);
        chk("arst lo", lo_out, 32'd0);
        chk("arst busy", {31'd0, md_busy}, 32'd0);
        chk("arst dbz", {31'd0, div_by_zero}, 32'd0);
        chk("arst done", {31'd0, md_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
